// File: rtl/input_job_arbiter.sv
// Round-robin arbiter that locks one compression-job stream onto the shared
// hash-engine input until that stream's delimited beat is accepted.
module input_job_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_BYTES = 16,
    parameter int CNT_WIDTH  = 16,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int DW        = DATA_BYTES * 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_delim,
    input  logic [NUM_REQ*DW-1:0]   req_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_delim,
    output logic [DW-1:0]           out_data,
    output logic [ID_W-1:0]         out_src_id,
    output logic                    job_done,
    output logic [ID_W-1:0]         job_src_id,
    output logic [CNT_WIDTH-1:0]    job_beats
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]           state_r;
    logic [ID_W-1:0]      grant_id_r;
    logic [ID_W-1:0]      rr_ptr_r;
    logic [CNT_WIDTH-1:0] beat_cnt_r;
    logic                 job_done_r;
    logic [ID_W-1:0]      job_src_id_r;
    logic [CNT_WIDTH-1:0] job_beats_r;

    logic [ID_W-1:0]      pick_id_s;
    logic                 pick_found_s;
    logic [CNT_WIDTH-1:0] beat_inc_s;
    logic                 xfer_s;
    logic                 last_xfer_s;

    // Round-robin pick: scanning downward lets the lowest offset from rr_ptr win.
    always_comb begin
        pick_found_s = |req_valid;
        pick_id_s    = rr_ptr_r;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pick_id_s = req_valid[rr_ptr_r + ID_W'(k)] ? (rr_ptr_r + ID_W'(k)) : pick_id_s;
        end
    end

    // Zero-latency pass-through of the granted stream; everything is gated off in IDLE.
    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_delim = 1'b0;
        out_data  = req_data[grant_id_r * DW +: DW];
        if (state_r == ST_GRANT) begin
            req_ready[grant_id_r] = out_ready;
            out_valid             = req_valid[grant_id_r];
            out_delim             = req_delim[grant_id_r];
        end else begin
            req_ready = '0;
            out_valid = 1'b0;
            out_delim = 1'b0;
        end
    end

    assign xfer_s      = out_valid && out_ready;
    assign last_xfer_s = xfer_s && out_delim;
    assign beat_inc_s  = (&beat_cnt_r) ? beat_cnt_r : beat_cnt_r + CNT_WIDTH'(1'b1);

    // Grant FSM, beat counting and the one-cycle job completion report.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            grant_id_r   <= '0;
            rr_ptr_r     <= '0;
            beat_cnt_r   <= '0;
            job_done_r   <= 1'b0;
            job_src_id_r <= '0;
            job_beats_r  <= '0;
        end else begin
            job_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        grant_id_r <= pick_id_s;
                        beat_cnt_r <= '0;
                        state_r    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // The grant only moves on a delim transfer, so stalls and gaps keep the lock.
                    if (last_xfer_s) begin
                        job_done_r   <= 1'b1;
                        job_src_id_r <= grant_id_r;
                        job_beats_r  <= beat_inc_s;
                        rr_ptr_r     <= grant_id_r + ID_W'(1'b1);
                        state_r      <= ST_IDLE;
                    end else if (xfer_s) begin
                        beat_cnt_r <= beat_inc_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_src_id = grant_id_r;
    assign job_done   = job_done_r;
    assign job_src_id = job_src_id_r;
    assign job_beats  = job_beats_r;

endmodule

// File: tb/tb_input_job_arbiter.sv
// Directed bench for input_job_arbiter: arbitration order, lock, backpressure,
// counter saturation and mid-job reset, with hand-computed expectations.
module tb_input_job_arbiter;

    localparam int NR = 4;
    localparam int DB = 4;
    localparam int CW = 4;
    localparam int DW = DB * 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    req_delim;
    logic [NR*DW-1:0] req_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_delim;
    logic [DW-1:0]    out_data;
    logic [1:0]       out_src_id;
    logic             job_done;
    logic [1:0]       job_src_id;
    logic [CW-1:0]    job_beats;

    int checks = 0;
    int errors = 0;

    input_job_arbiter #(.NUM_REQ(NR), .DATA_BYTES(DB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_delim(req_delim), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_delim(out_delim), .out_data(out_data),
        .out_src_id(out_src_id), .job_done(job_done), .job_src_id(job_src_id), .job_beats(job_beats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int ord[5] = '{0, 1, 2, 3, 0};
        int prv[5] = '{3, 0, 1, 2, 3};
        int bpv[5] = '{1, 2, 2, 2, 2};

        rst_n = 1'b0; req_valid = '0; req_delim = '0; req_data = '0; out_ready = 1'b1;
        nxt(); nxt();
        smp();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_out_src_id", out_src_id, 2'd0);
        chk("rst_job_done", job_done, 1'b0);
        chk("rst_job_src_id", job_src_id, 2'd0);
        chk("rst_job_beats", job_beats, 4'd0);

        // Single requester 2, three beats
        nxt(); rst_n = 1'b1; req_valid = 4'b0100; req_data[2*DW +: DW] = 32'hA000_0001;
        smp();
        chk("t1_idle_out_valid", out_valid, 1'b0);
        chk("t1_idle_req_ready", req_ready, 4'b0000);
        nxt(); smp();
        chk("t1_b1_out_valid", out_valid, 1'b1);
        chk("t1_b1_src", out_src_id, 2'd2);
        chk("t1_b1_req_ready", req_ready, 4'b0100);
        chk("t1_b1_data", out_data, 32'hA000_0001);
        chk("t1_b1_delim", out_delim, 1'b0);
        nxt(); req_data[2*DW +: DW] = 32'hA000_0002; smp();
        chk("t1_b2_out_valid", out_valid, 1'b1);
        chk("t1_b2_data", out_data, 32'hA000_0002);
        nxt(); req_data[2*DW +: DW] = 32'hA000_0003; req_delim = 4'b0100; smp();
        chk("t1_b3_delim", out_delim, 1'b1);
        chk("t1_b3_src", out_src_id, 2'd2);
        chk("t1_b3_job_done", job_done, 1'b0);
        nxt(); req_valid = '0; req_delim = '0; smp();
        chk("t1_done", job_done, 1'b1);
        chk("t1_done_src", job_src_id, 2'd2);
        chk("t1_done_beats", job_beats, 4'd3);
        chk("t1_bubble_out_valid", out_valid, 1'b0);
        chk("t1_bubble_src_hold", out_src_id, 2'd2);
        nxt(); smp();
        chk("t1_done_one_cycle", job_done, 1'b0);

        // rr_ptr is now 3: requester 3 beats 0, single-beat job
        nxt(); req_valid = 4'b1001; req_delim = 4'b1001; req_data[3*DW +: DW] = 32'hB000_0003; smp();
        chk("rr_idle_out_valid", out_valid, 1'b0);
        nxt(); smp();
        chk("rr_grant_src", out_src_id, 2'd3);
        chk("rr_req_ready", req_ready, 4'b1000);
        chk("rr_delim", out_delim, 1'b1);
        chk("rr_data", out_data, 32'hB000_0003);
        nxt(); req_valid = 4'b1111; req_delim = 4'b0000; smp();

        // All four contending with 2-beat jobs: order 0,1,2,3,0
        for (int j = 0; j < 5; j++) begin
            chk("rr4_bubble_out_valid", out_valid, 1'b0);
            chk("rr4_bubble_done", job_done, 1'b1);
            chk("rr4_bubble_done_src", job_src_id, 64'(prv[j]));
            chk("rr4_bubble_done_beats", job_beats, 64'(bpv[j]));
            nxt(); smp();
            chk("rr4_b1_src", out_src_id, 64'(ord[j]));
            chk("rr4_b1_req_ready", req_ready, 64'(4'b0001 << ord[j]));
            chk("rr4_b1_out_valid", out_valid, 1'b1);
            chk("rr4_b1_job_done", job_done, 1'b0);
            nxt(); req_delim = 4'b1111; smp();
            chk("rr4_b2_src", out_src_id, 64'(ord[j]));
            chk("rr4_b2_delim", out_delim, 1'b1);
            nxt(); req_delim = 4'b0000; smp();
        end
        chk("rr4_last_done", job_done, 1'b1);
        chk("rr4_last_done_src", job_src_id, 2'd0);
        chk("rr4_last_out_valid", out_valid, 1'b0);
        req_valid = '0;

        // Lock: requester 1 stalls 5 cycles while requester 0 waits
        nxt(); req_valid = 4'b0011; req_data[DW +: DW] = 32'hC000_0001; smp();
        chk("lk_idle_out_valid", out_valid, 1'b0);
        nxt(); smp();
        chk("lk_grant_src", out_src_id, 2'd1);
        chk("lk_grant_req_ready", req_ready, 4'b0010);
        nxt(); req_valid = 4'b0001; smp();
        for (int s = 0; s < 5; s++) begin
            chk("lk_stall_src", out_src_id, 2'd1);
            chk("lk_stall_req_ready", req_ready, 4'b0010);
            chk("lk_stall_out_valid", out_valid, 1'b0);
            nxt();
            if (s == 4) begin
                req_valid = 4'b0011;
                req_delim = 4'b0010;
            end
            smp();
        end
        chk("lk_delim_out_valid", out_valid, 1'b1);
        chk("lk_delim", out_delim, 1'b1);
        chk("lk_delim_src", out_src_id, 2'd1);
        nxt(); req_valid = '0; req_delim = '0; smp();
        chk("lk_done", job_done, 1'b1);
        chk("lk_done_src", job_src_id, 2'd1);
        chk("lk_done_beats", job_beats, 4'd2);

        // Backpressure on requester 2: out_ready 1,0,0,1 then stall on the delim beat
        nxt(); req_valid = 4'b0100; req_data[2*DW +: DW] = 32'hD000_0000; smp();
        chk("bp_idle_out_valid", out_valid, 1'b0);
        nxt(); smp();
        chk("bp_d0_data", out_data, 32'hD000_0000);
        chk("bp_d0_req_ready", req_ready, 4'b0100);
        nxt(); req_data[2*DW +: DW] = 32'hD000_0001; out_ready = 1'b0; smp();
        chk("bp_d1_out_valid", out_valid, 1'b1);
        chk("bp_d1_data", out_data, 32'hD000_0001);
        chk("bp_d1_req_ready", req_ready, 4'b0000);
        nxt(); smp();
        chk("bp_d1_hold_out_valid", out_valid, 1'b1);
        chk("bp_d1_hold_data", out_data, 32'hD000_0001);
        nxt(); out_ready = 1'b1; smp();
        chk("bp_d1_go_data", out_data, 32'hD000_0001);
        chk("bp_d1_go_req_ready", req_ready, 4'b0100);
        nxt(); req_data[2*DW +: DW] = 32'hD000_0002; smp();
        chk("bp_d2_data", out_data, 32'hD000_0002);
        nxt(); req_data[2*DW +: DW] = 32'hD000_0003; req_delim = 4'b0100; out_ready = 1'b0; smp();
        chk("bp_d3_delim", out_delim, 1'b1);
        chk("bp_d3_req_ready", req_ready, 4'b0000);
        nxt(); smp();
        chk("bp_d3_held_no_done", job_done, 1'b0);
        chk("bp_d3_held_out_valid", out_valid, 1'b1);
        nxt(); out_ready = 1'b1; smp();
        chk("bp_d3_go_req_ready", req_ready, 4'b0100);
        nxt(); req_valid = '0; req_delim = '0; smp();
        chk("bp_done", job_done, 1'b1);
        chk("bp_done_src", job_src_id, 2'd2);
        chk("bp_done_beats", job_beats, 4'd4);

        // 20-beat job from requester 3 saturates a 4-bit counter
        nxt(); req_valid = 4'b1000; smp();
        chk("sat_idle_out_valid", out_valid, 1'b0);
        for (int i = 0; i < 20; i++) begin
            nxt();
            req_delim = (i == 19) ? 4'b1000 : 4'b0000;
            req_data[3*DW +: DW] = 32'(i);
            smp();
            chk("sat_beat_src", out_src_id, 2'd3);
            chk("sat_beat_data", out_data, 64'(i));
        end
        nxt(); req_valid = '0; req_delim = '0; smp();
        chk("sat_done", job_done, 1'b1);
        chk("sat_done_src", job_src_id, 2'd3);
        chk("sat_done_beats", job_beats, 4'hF);

        // Reset after two beats of a requester-1 job
        nxt(); req_valid = 4'b0010; smp();
        chk("rs_idle_out_valid", out_valid, 1'b0);
        nxt(); smp();
        chk("rs_grant_src", out_src_id, 2'd1);
        nxt(); smp();
        chk("rs_b2_out_valid", out_valid, 1'b1);
        nxt(); rst_n = 1'b0; smp();
        nxt(); rst_n = 1'b1; req_valid = 4'b1111; smp();
        chk("rs_out_valid", out_valid, 1'b0);
        chk("rs_req_ready", req_ready, 4'b0000);
        chk("rs_job_done", job_done, 1'b0);
        chk("rs_out_src_id", out_src_id, 2'd0);
        chk("rs_job_src_id", job_src_id, 2'd0);
        chk("rs_job_beats", job_beats, 4'd0);
        nxt(); smp();
        chk("rs_next_src", out_src_id, 2'd0);
        chk("rs_next_req_ready", req_ready, 4'b0001);
        chk("rs_next_out_valid", out_valid, 1'b1);
        nxt(); req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
